branch_resolve_unit: RTL

- Parametrised, registered branch resolution stage for the MIPS32 pipeline.
- Evaluates every conditional branch (BEQ/BNE/BGTZ/BLEZ, REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL) on WIDTH-bit operands.
- Computes the branch target and the link address, and registers the result with a valid handshake.
- Holds a 2-bit saturating branch history table (BHT) that serves fetch-stage predictions and is trained by each resolved branch.

---
 rtl/branch_resolve_unit_pkg.sv | 58 +++++
 rtl/branch_bht.sv | 42 ++++
 rtl/branch_resolve_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit_pkg
// Purpose  : Shared MIPS32 branch encodings, BHT counter states and the
//            2-bit saturating counter update helper.
// Ports    : none (package)
// Config   : BRANCH_LIKELY_EN enables recognition of the *L encodings below.
// Revision : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

  // Primary opcodes
  localparam logic [5:0] EXE_BEQ         = 6'b000100;
  localparam logic [5:0] EXE_BNE         = 6'b000101;
  localparam logic [5:0] EXE_BLEZ        = 6'b000110;
  localparam logic [5:0] EXE_BGTZ        = 6'b000111;
  localparam logic [5:0] EXE_REGIMM_INST = 6'b000001;

  // REGIMM rt sub-opcodes
  localparam logic [4:0] EXE_BLTZ        = 5'b00000;
  localparam logic [4:0] EXE_BGEZ        = 5'b00001;
  localparam logic [4:0] EXE_BLTZAL      = 5'b10000;
  localparam logic [4:0] EXE_BGEZAL      = 5'b10001;

  // Branch-likely encodings
  localparam logic [5:0] EXE_BEQL        = 6'b010100;
  localparam logic [5:0] EXE_BNEL        = 6'b010101;
  localparam logic [5:0] EXE_BLEZL       = 6'b010110;
  localparam logic [5:0] EXE_BGTZL       = 6'b010111;
  localparam logic [4:0] EXE_BLTZL       = 5'b00010;
  localparam logic [4:0] EXE_BGEZL       = 5'b00011;
  localparam logic [4:0] EXE_BLTZALL     = 5'b10010;
  localparam logic [4:0] EXE_BGEZALL     = 5'b10011;

  localparam logic [31:0] ZeroWord       = 32'h0000_0000;

  // 2-bit saturating counter states; the MSB is the taken prediction
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_e;

  localparam bht_ctr_e BHT_INIT = WNT;

  function automatic bht_ctr_e bht_next(input bht_ctr_e cur, input logic taken);
    case (cur)
      SNT:     bht_next = taken ? WNT : SNT;
      WNT:     bht_next = taken ? WT  : SNT;
      WT:      bht_next = taken ? ST  : WNT;
      ST:      bht_next = taken ? ST  : WT;
      default: bht_next = cur;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_bht.sv
`default_nettype none
// ============================================================================
// Module   : branch_bht
// Purpose  : Branch history table of 2-bit saturating counters with one
//            combinational read port and one synchronous update port.
//            Read returns the pre-update value on a same-entry collision.
// Ports    : clk, rst (async, active-high)
//            rd_idx / rd_ctr        - lookup index and counter value
//            wr_en / wr_idx / wr_taken - training request
// Revision : 1.0 - initial release
// ============================================================================
module branch_bht
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_e ctr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= BHT_INIT;
      end
    end else if (wr_en) begin
      ctr[wr_idx] <= bht_next(ctr[wr_idx], wr_taken);
    end
  end

  assign rd_ctr = ctr[rd_idx];

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Registered MIPS32 conditional-branch resolution stage with
//            target/link computation and a 2-bit BHT trained by each result.
// Ports    : clk, rst (async, active-high)
//            pred_pc -> pred_taken            fetch-side BHT lookup
//            in_valid/in_op/in_rt/in_a/in_b/in_pc/in_imm/in_pred  branch in
//            stall, flush                     stage control
//            res_valid/res_taken/res_target/res_link/res_link_we/
//            res_mispredict/res_nullify       registered result
// Config   : define BRANCH_LIKELY_EN to resolve the branch-likely family
//            (statically predicted taken, no BHT training, nullify on miss).
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 64,
  parameter int BHT_IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pred_pc,
  output logic             pred_taken,
  input  logic             in_valid,
  input  logic [5:0]       in_op,
  input  logic [4:0]       in_rt,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [15:0]      in_imm,
  input  logic             in_pred,
  input  logic             stall,
  input  logic             flush,
  output logic             res_valid,
  output logic             res_taken,
  output logic [WIDTH-1:0] res_target,
  output logic [WIDTH-1:0] res_link,
  output logic             res_link_we,
  output logic             res_mispredict,
  output logic             res_nullify
);

  logic sign_a, zero_a, eq_ab;
  logic is_branch, cond, is_likely, link_we_d;
  logic capture, train_en, trained, res_likely;
  logic [BHT_IDX_W-1:0] res_idx;
  logic [WIDTH-1:0] off_sext;
  logic [1:0] pred_ctr;
  logic unused_bits;

  assign sign_a = in_a[WIDTH-1];
  assign zero_a = (in_a == '0);
  assign eq_ab  = (in_a == in_b);

  // Decode: anything not listed is a non-branch and never produces a result
  always_comb begin
    is_branch = 1'b0;
    cond      = 1'b0;
    is_likely = 1'b0;
    link_we_d = 1'b0;
    case (in_op)
      EXE_BEQ:  begin is_branch = 1'b1; cond = eq_ab;              end
      EXE_BNE:  begin is_branch = 1'b1; cond = ~eq_ab;             end
      EXE_BGTZ: begin is_branch = 1'b1; cond = ~sign_a & ~zero_a;  end
      EXE_BLEZ: begin is_branch = 1'b1; cond = sign_a | zero_a;    end
`ifdef BRANCH_LIKELY_EN
      EXE_BEQL:  begin is_branch = 1'b1; is_likely = 1'b1; cond = eq_ab;             end
      EXE_BNEL:  begin is_branch = 1'b1; is_likely = 1'b1; cond = ~eq_ab;            end
      EXE_BGTZL: begin is_branch = 1'b1; is_likely = 1'b1; cond = ~sign_a & ~zero_a; end
      EXE_BLEZL: begin is_branch = 1'b1; is_likely = 1'b1; cond = sign_a | zero_a;   end
`endif
      EXE_REGIMM_INST: begin
        case (in_rt)
          EXE_BLTZ:   begin is_branch = 1'b1; cond = sign_a;  end
          EXE_BGEZ:   begin is_branch = 1'b1; cond = ~sign_a; end
          EXE_BLTZAL: begin is_branch = 1'b1; cond = sign_a;  link_we_d = 1'b1; end
          EXE_BGEZAL: begin is_branch = 1'b1; cond = ~sign_a; link_we_d = 1'b1; end
`ifdef BRANCH_LIKELY_EN
          EXE_BLTZL:   begin is_branch = 1'b1; is_likely = 1'b1; cond = sign_a;  end
          EXE_BGEZL:   begin is_branch = 1'b1; is_likely = 1'b1; cond = ~sign_a; end
          EXE_BLTZALL: begin is_branch = 1'b1; is_likely = 1'b1; cond = sign_a;  link_we_d = 1'b1; end
          EXE_BGEZALL: begin is_branch = 1'b1; is_likely = 1'b1; cond = ~sign_a; link_we_d = 1'b1; end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign off_sext = WIDTH'($signed(in_imm));
  assign capture  = in_valid & is_branch & ~stall & ~flush;

  // Train exactly once per result; a flush drops a result not yet trained.
  // Likely branches are statically taken and leave the table alone.
  assign train_en = res_valid & ~trained & ~res_likely & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_target     <= '0;
      res_link       <= '0;
      res_link_we    <= 1'b0;
      res_mispredict <= 1'b0;
      res_nullify    <= 1'b0;
      res_likely     <= 1'b0;
      res_idx        <= '0;
      trained        <= 1'b0;
    end else begin
      if (train_en) begin
        trained <= 1'b1;
      end
      if (flush) begin
        res_valid <= 1'b0;
      end else if (capture) begin
        res_valid      <= 1'b1;
        res_taken      <= cond;
        res_target     <= in_pc + WIDTH'(4) + (off_sext << 2);
        res_link       <= in_pc + WIDTH'(8);
        res_link_we    <= link_we_d;
        res_mispredict <= is_likely ? ~cond : (cond ^ in_pred);
        res_nullify    <= is_likely & ~cond;
        res_likely     <= is_likely;
        res_idx        <= in_pc[BHT_IDX_W+1:2];
        trained        <= 1'b0;
      end else if (!stall) begin
        res_valid <= 1'b0;
      end
    end
  end

  branch_bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pred_pc[BHT_IDX_W+1:2]),
    .rd_ctr   (pred_ctr),
    .wr_en    (train_en),
    .wr_idx   (res_idx),
    .wr_taken (res_taken)
  );

  assign pred_taken = pred_ctr[1];

  // Only the index bits of pred_pc and the counter MSB are consumed
  assign unused_bits = ^{pred_pc, pred_ctr[0]};

endmodule
`default_nettype wire
